// File: rtl/alu_irq_pipe_if.sv
// ----------------------------------------------------------------------------
// alu_irq_pipe_if
//   Bus-side bundle for alu_irq_pipe: issue controls, operands, compare-register
//   configuration, IRQ clear, and the result/interrupt outputs.
//   master : operand/config source (drives issue, operands, cfg_*, alu_irq_clr)
//   slave  : the ALU pipeline (drives alu_out*, alu_irq*)
// ----------------------------------------------------------------------------
interface alu_irq_pipe_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic             alu_enable;
    logic             alu_enable_a;
    logic             alu_enable_b;
    logic [1:0]       alu_op_a;
    logic [1:0]       alu_op_b;
    logic [WIDTH-1:0] alu_in_a;
    logic [WIDTH-1:0] alu_in_b;
    logic             cfg_we;
    logic [2:0]       cfg_sel;
    logic [WIDTH-1:0] cfg_data;
    logic             alu_irq_clr;
    logic [WIDTH-1:0] alu_out;
    logic             alu_out_valid;
    logic             alu_irq;
    logic [2:0]       alu_irq_src;
    logic [CNT_W-1:0] alu_irq_count;

    modport master (
        output alu_enable, alu_enable_a, alu_enable_b, alu_op_a, alu_op_b,
               alu_in_a, alu_in_b, cfg_we, cfg_sel, cfg_data, alu_irq_clr,
        input  alu_out, alu_out_valid, alu_irq, alu_irq_src, alu_irq_count
    );

    modport slave (
        input  alu_enable, alu_enable_a, alu_enable_b, alu_op_a, alu_op_b,
               alu_in_a, alu_in_b, cfg_we, cfg_sel, cfg_data, alu_irq_clr,
        output alu_out, alu_out_valid, alu_irq, alu_irq_src, alu_irq_count
    );
endinterface

// File: rtl/alu_irq_pipe.sv
// ----------------------------------------------------------------------------
// alu_irq_pipe
//   Two-bank bitwise logic ALU with a two-stage pipeline. Stage 1 registers the
//   result and its {bank,op} tag; stage 2 compares the registered result with
//   the per-opcode compare register selected by the tag and raises a sticky
//   IRQ, capturing the first hit's source and counting hits (saturating).
// Ports
//   alu_clk : clock, rising edge
//   rst_n   : asynchronous active-low reset
//   bus     : alu_irq_pipe_if.slave (issue/operands/config in, result/IRQ out)
// ----------------------------------------------------------------------------
module alu_irq_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic           alu_clk,
    input  logic           rst_n,
    alu_irq_pipe_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Stage 1
    logic [WIDTH-1:0] out_q, out_d;
    logic             out_valid_q, out_valid_d;
    logic [2:0]       tag_q, tag_d;
    logic             tag_valid_q, tag_valid_d;

    // Stage 2 / IRQ state
    logic             irq_q, irq_d;
    logic [2:0]       irq_src_q, irq_src_d;
    logic [CNT_W-1:0] irq_count_q, irq_count_d;

    // Compare registers, indexed by {bank, op}
    logic [WIDTH-1:0] cmp_q [8];
    logic [WIDTH-1:0] cmp_d [8];

    logic             issue;
    logic [2:0]       sel_tag;
    logic [WIDTH-1:0] result;
    logic             hit;

    // Issue decode and result; bank A wins when both banks are selected.
    always_comb begin
        issue   = bus.alu_enable && (bus.alu_enable_a || bus.alu_enable_b);
        sel_tag = bus.alu_enable_a ? {1'b0, bus.alu_op_a} : {1'b1, bus.alu_op_b};
        result  = '0;
        unique case (sel_tag)
            3'b000: result =   bus.alu_in_a & bus.alu_in_b;
            3'b001: result = ~(bus.alu_in_a & bus.alu_in_b);
            3'b010: result =   bus.alu_in_a | bus.alu_in_b;
            3'b011: result =   bus.alu_in_a ^ bus.alu_in_b;
            3'b100: result = ~(bus.alu_in_a ^ bus.alu_in_b);
            3'b101: result =   bus.alu_in_a & bus.alu_in_b;
            3'b110: result = ~(bus.alu_in_a | bus.alu_in_b);
            3'b111: result =   bus.alu_in_a | bus.alu_in_b;
            default: result = '0;
        endcase
    end

    always_comb begin
        out_d       = issue ? result : out_q;
        out_valid_d = issue;
        tag_d       = issue ? sel_tag : '0;
        tag_valid_d = issue;
    end

    // Compare uses cmp_q, so a config write at the same edge sees the old value.
    assign hit = tag_valid_q && (out_q == cmp_q[tag_q]);

    always_comb begin
        irq_d       = irq_q;
        irq_src_d   = irq_src_q;
        irq_count_d = irq_count_q;
        if (hit) begin
            irq_d = 1'b1;
            // A coincident clear restarts the capture with this hit.
            if (!irq_q || bus.alu_irq_clr) begin
                irq_src_d = tag_q;
            end
            if (bus.alu_irq_clr) begin
                irq_count_d = CNT_ONE;
            end else if (irq_count_q != '1) begin
                irq_count_d = irq_count_q + CNT_ONE;
            end
        end else if (bus.alu_irq_clr) begin
            irq_d       = 1'b0;
            irq_src_d   = '0;
            irq_count_d = '0;
        end
    end

    always_comb begin
        cmp_d = cmp_q;
        if (bus.cfg_we) begin
            cmp_d[bus.cfg_sel] = bus.cfg_data;
        end
    end

    always_ff @(posedge alu_clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            tag_q       <= '0;
            tag_valid_q <= 1'b0;
            irq_q       <= 1'b0;
            irq_src_q   <= '0;
            irq_count_q <= '0;
            // A1 and A3 reset to zero, every other compare register to all-ones.
            for (int unsigned i = 0; i < 8; i++) begin
                if (i == 1 || i == 3) begin
                    cmp_q[i[2:0]] <= '0;
                end else begin
                    cmp_q[i[2:0]] <= '1;
                end
            end
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            tag_q       <= tag_d;
            tag_valid_q <= tag_valid_d;
            irq_q       <= irq_d;
            irq_src_q   <= irq_src_d;
            irq_count_q <= irq_count_d;
            cmp_q       <= cmp_d;
        end
    end

    assign bus.alu_out       = out_q;
    assign bus.alu_out_valid = out_valid_q;
    assign bus.alu_irq       = irq_q;
    assign bus.alu_irq_src   = irq_src_q;
    assign bus.alu_irq_count = irq_count_q;

endmodule

// File: tb/tb_alu_irq_pipe.sv
// ----------------------------------------------------------------------------
// tb_alu_irq_pipe
//   Scoreboard bench for alu_irq_pipe (WIDTH=8, CNT_W=4). The driver applies
//   inputs on the falling edge and pushes the expected post-edge state into
//   queues; an independent monitor samples 1 time unit after each rising edge.
// ----------------------------------------------------------------------------
module tb_alu_irq_pipe;

    localparam int W  = 8;
    localparam int CW = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic clk;
    logic rst_n;

    alu_irq_pipe_if #(.WIDTH(W), .CNT_W(CW)) bus ();

    alu_irq_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
        .alu_clk (clk),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] out;
        logic         valid;
        logic         irq;
        logic [2:0]   src;
        int           cnt;
    } stat_t;

    stat_t        stat_q[$];
    logic [W-1:0] res_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [W-1:0] m_cmp [8];
    logic [W-1:0] m_out;
    logic         m_valid;
    bit           m_pend;      // a result awaits its compare next cycle
    logic [2:0]   m_pend_tag;
    logic         m_irq;
    logic [2:0]   m_src;
    int           m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] ref_op(input logic [2:0] t, input logic [W-1:0] a, input logic [W-1:0] b);
        case (t)
            3'd0: return a & b;
            3'd1: return ~(a & b);
            3'd2: return a | b;
            3'd3: return a ^ b;
            3'd4: return ~(a ^ b);
            3'd5: return a & b;
            3'd6: return ~(a | b);
            default: return a | b;
        endcase
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 8; i++) m_cmp[i] = (i == 1 || i == 3) ? '0 : '1;
        m_out = '0; m_valid = 0; m_pend = 0; m_pend_tag = '0;
        m_irq = 0; m_src = '0; m_cnt = 0;
    endtask

    task automatic push_stat();
        stat_t s;
        s.out = m_out; s.valid = m_valid; s.irq = m_irq; s.src = m_src; s.cnt = m_cnt;
        stat_q.push_back(s);
    endtask

    // Advance the model across one rising edge with the given inputs.
    task automatic m_step(input bit en, input bit ea, input bit eb,
                          input logic [1:0] oa, input logic [1:0] ob,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit we, input logic [2:0] sel, input logic [W-1:0] d,
                          input bit clr);
        bit hit;
        bit iss;
        logic [2:0] t;
        hit = m_pend && (m_out == m_cmp[m_pend_tag]);
        if (hit) begin
            if (!m_irq || clr) m_src = m_pend_tag;
            m_cnt = clr ? 1 : ((m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX);
            m_irq = 1;
        end else if (clr) begin
            m_irq = 0; m_src = '0; m_cnt = 0;
        end
        if (we) m_cmp[sel] = d;
        iss = en && (ea || eb);
        t = ea ? {1'b0, oa} : {1'b1, ob};
        m_pend = iss;
        m_pend_tag = t;
        m_valid = iss;
        if (iss) begin
            m_out = ref_op(t, a, b);
            res_q.push_back(m_out);
        end
        push_stat();
    endtask

    task automatic cyc(input bit en, input bit ea, input bit eb,
                       input logic [1:0] oa, input logic [1:0] ob,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit we = 0, input logic [2:0] sel = 3'd0,
                       input logic [W-1:0] d = '0, input bit clr = 0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.alu_enable = en; bus.alu_enable_a = ea; bus.alu_enable_b = eb;
        bus.alu_op_a = oa; bus.alu_op_b = ob;
        bus.alu_in_a = a; bus.alu_in_b = b;
        bus.cfg_we = we; bus.cfg_sel = sel; bus.cfg_data = d;
        bus.alu_irq_clr = clr;
        m_step(en, ea, eb, oa, ob, a, b, we, sel, d, clr);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 2'd0, 2'd0, '0, '0);
    endtask

    task automatic rst_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst_n = 1'b0;
            bus.alu_enable = 0; bus.alu_enable_a = 0; bus.alu_enable_b = 0;
            bus.cfg_we = 0; bus.alu_irq_clr = 0;
            m_reset();
            push_stat();
        end
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 6))
            0: return 8'h00;
            1: return 8'hFF;
            2: return 8'h55;
            3: return 8'hAA;
            4: return 8'h0F;
            5: return 8'hF0;
            default: return W'($urandom());
        endcase
    endfunction

    // Monitor: decoupled from the driver, consumes expectations as outputs appear.
    initial begin
        stat_t s;
        forever begin
            @(posedge clk);
            #1;
            if (stat_q.size() > 0) begin
                s = stat_q.pop_front();
                chk("alu_out_valid", 32'(bus.alu_out_valid), 32'(s.valid));
                chk("alu_out", 32'(bus.alu_out), 32'(s.out));
                chk("alu_irq", 32'(bus.alu_irq), 32'(s.irq));
                chk("alu_irq_src", 32'(bus.alu_irq_src), 32'(s.src));
                chk("alu_irq_count", 32'(bus.alu_irq_count), 32'(s.cnt));
            end
            if (bus.alu_out_valid === 1'b1) begin
                if (res_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_result: got %0h expected none", bus.alu_out);
                end else begin
                    chk("result_scoreboard", 32'(bus.alu_out), 32'(res_q.pop_front()));
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        bus.alu_enable = 0; bus.alu_enable_a = 0; bus.alu_enable_b = 0;
        bus.alu_op_a = '0; bus.alu_op_b = '0;
        bus.alu_in_a = '0; bus.alu_in_b = '0;
        bus.cfg_we = 0; bus.cfg_sel = '0; bus.cfg_data = '0;
        bus.alu_irq_clr = 0;
        m_reset();

        // Reset then idle
        rst_cycles(3);
        idle(5);

        // A op00 FF&FF hits A0 (all-ones)
        cyc(1, 1, 0, 2'b00, 2'b00, 8'hFF, 8'hFF);
        idle(2);

        // Program B2 = 55, then B op10 ~(AA|00) = 55 -> hit; clear first
        cyc(0, 0, 0, 2'b00, 2'b00, '0, '0, 1, 3'b110, 8'h55, 1);
        cyc(1, 0, 1, 2'b00, 2'b10, 8'hAA, 8'h00);
        idle(2);

        // Both banks: bank A xor wins over bank B xnor
        cyc(1, 1, 1, 2'b11, 2'b00, 8'h0F, 8'hF0);
        idle(2);

        // Clear coinciding with a hit, then saturate the counter with 20 hits
        cyc(1, 1, 0, 2'b00, 2'b00, 8'hFF, 8'hFF);
        cyc(0, 0, 0, 2'b00, 2'b00, '0, '0, 0, 3'd0, '0, 1);
        idle(1);
        cyc(0, 0, 0, 2'b00, 2'b00, '0, '0, 0, 3'd0, '0, 1);
        for (int i = 0; i < 20; i++) cyc(1, 0, 1, 2'b00, 2'b11, 8'hF0, 8'h0F);
        cyc(1, 1, 0, 2'b00, 2'b00, 8'hFF, 8'hFF);
        idle(2);

        // Config write at the compare edge: old value still used
        cyc(0, 0, 0, 2'b00, 2'b00, '0, '0, 0, 3'd0, '0, 1);
        cyc(1, 1, 0, 2'b00, 2'b00, 8'hFF, 8'hFF);
        cyc(0, 0, 0, 2'b00, 2'b00, '0, '0, 1, 3'd0, 8'h00, 0);
        idle(2);

        // Reset with a hitting op in flight
        cyc(1, 1, 0, 2'b00, 2'b00, 8'hFF, 8'hFF);
        rst_cycles(2);
        idle(4);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 3) != 0, 1'($urandom()), 1'($urandom()),
                2'($urandom()), 2'($urandom()), pick(), pick(),
                $urandom_range(0, 7) == 0, 3'($urandom()), pick(),
                $urandom_range(0, 15) == 0);
        end
        idle(3);

        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (stat_q.size() != 0 || res_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d/%0d pending expected 0/0", stat_q.size(), res_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
